// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Round-robin on ties, optional lock for back-to-back ownership, registered completions.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,

  output logic          mem_w_en,
  output logic [31:0]   mem_w_addr,
  output logic [31:0]   mem_w_data,
  input  logic [31:0]   mem_r_data
);

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Misaligned or beyond the last word of the memory.
  function automatic logic addr_err(input logic [AW-1:0] a);
    logic [AW:0] widx;
    widx = {3'b000, a[AW-1:2]};
    return (a[1:0] != 2'b00) || (widx >= DEPTH_L);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        gnt0, gnt1, any_gnt;
  logic [AW-1:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [31:0] cpl_rdata;

  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        err0_q, err0_d, err1_q, err1_d;

  // rr_q=1 means m1 was granted most recently, so m0 wins the next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_OWN0: gnt0 = m0_req;
        ST_OWN1: gnt1 = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            gnt0 = rr_q;
            gnt1 = !rr_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OWN0: if (!m0_req || !m0_lock) state_d = ST_ARB;
      ST_OWN1: if (!m1_req || !m1_lock) state_d = ST_ARB;
      default: begin
        if (gnt0 && m0_lock)      state_d = ST_OWN0;
        else if (gnt1 && m1_lock) state_d = ST_OWN1;
        else                      state_d = ST_ARB;
      end
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt1)      rr_d = 1'b1;
    else if (gnt0) rr_d = 1'b0;
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_we    = gnt1 ? m1_we    : m0_we;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign sel_err   = addr_err(sel_addr);

  assign mem_w_en   = any_gnt && sel_we && !sel_err;
  assign mem_w_data = sel_wdata;
  assign cpl_rdata  = (!sel_we && !sel_err) ? mem_r_data : 32'd0;

  generate
    if (AW >= 32) begin : g_addr_trunc
      assign mem_w_addr = sel_addr[31:0];
    end else begin : g_addr_ext
      assign mem_w_addr = {{(32-AW){1'b0}}, sel_addr};
    end
  endgenerate

  always_comb begin
    rdata0_d = rdata0_q;
    err0_d   = err0_q;
    rdata1_d = rdata1_q;
    err1_d   = err1_q;
    if (gnt0) begin
      rdata0_d = cpl_rdata;
      err0_d   = sel_err;
    end
    if (gnt1) begin
      rdata1_d = cpl_rdata;
      err1_d   = sel_err;
    end
  end

  // Completion stage: one-cycle pulse after each grant, data/err held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      rr_q      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a reference model,
// completions checked through per-requester expectation queues.
module tb_dmem_arbiter;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_w_en;
  logic [31:0] mem_w_addr, mem_w_data, mem_r_data;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initv(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Environment memory answering the DUT
  logic [31:0] tb_mem [DEPTH];
  logic        mem_init = 1'b1;
  assign mem_r_data = tb_mem[mem_w_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= initv(i);
    end else if (mem_w_en) begin
      tb_mem[mem_w_addr[7:2]] <= mem_w_data;
    end
  end

  // Reference model state
  typedef struct packed { logic [31:0] rd; logic err; } cpl_t;
  cpl_t        q0[$], q1[$];
  logic [31:0] ref_mem [DEPTH];
  int          owner = -1;
  bit          last1 = 1'b1;
  bit          mg0 = 1'b0, mg1 = 1'b0;
  logic [31:0] lrd [2];
  logic        ler [2];

  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = initv(i);

  always @(negedge clk) begin
    bit e0, e1, g_we, g_err, g_lock;
    int g;
    logic [31:0] g_addr, g_wd, exp_rd;
    if (!rst_n) begin
      chk("rst_gnt0", 32'(m0_gnt), 0);
      chk("rst_gnt1", 32'(m1_gnt), 0);
      chk("rst_wen",  32'(mem_w_en), 0);
      owner = -1; last1 = 1'b1; mg0 = 0; mg1 = 0;
    end else begin
      e0 = 0; e1 = 0;
      if (owner == 0)                e0 = m0_req;
      else if (owner == 1)           e1 = m1_req;
      else if (m0_req && m1_req)     begin if (last1) e0 = 1; else e1 = 1; end
      else                           begin e0 = m0_req; e1 = m1_req; end
      g      = e1 ? 1 : (e0 ? 0 : -1);
      g_addr = e1 ? m1_addr  : m0_addr;
      g_wd   = e1 ? m1_wdata : m0_wdata;
      g_we   = e1 ? m1_we    : m0_we;
      g_lock = e1 ? m1_lock  : m0_lock;
      g_err  = (g_addr % 4 != 0) || (g_addr / 4 >= DEPTH);
      chk("gnt0", 32'(m0_gnt), 32'(e0));
      chk("gnt1", 32'(m1_gnt), 32'(e1));
      chk("mem_w_en", 32'(mem_w_en), 32'(g >= 0 && g_we && !g_err));
      chk("mem_w_addr", mem_w_addr, g_addr);
      chk("mem_w_data", mem_w_data, g_wd);
      if (g >= 0) begin
        exp_rd = (!g_we && !g_err) ? ref_mem[g_addr / 4] : 32'd0;
        if (g_we && !g_err) ref_mem[g_addr / 4] = g_wd;
        if (g == 0) q0.push_back('{exp_rd, g_err}); else q1.push_back('{exp_rd, g_err});
        if (owner < 0 && g_lock) owner = g;
        last1 = (g == 1);
      end
      if (owner == 0 && (!m0_req || !m0_lock)) owner = -1;
      else if (owner == 1 && (!m1_req || !m1_lock)) owner = -1;
      mg0 = e0; mg1 = e1;
    end
  end

  task automatic mon(input int n, input logic v, input logic [31:0] rd, input logic e);
    cpl_t c;
    int   pend;
    pend = (n == 0) ? q0.size() : q1.size();
    chk($sformatf("m%0d_rvalid", n), 32'(v), 32'(pend > 0));
    if (v && pend > 0) begin
      if (n == 0) c = q0.pop_front(); else c = q1.pop_front();
      chk($sformatf("m%0d_rdata", n), rd, c.rd);
      chk($sformatf("m%0d_err", n), 32'(e), 32'(c.err));
      lrd[n] = c.rd; ler[n] = c.err;
    end else begin
      if (n == 0) q0.delete(); else q1.delete();
      if (!v) begin
        chk($sformatf("m%0d_rdata_hold", n), rd, lrd[n]);
        chk($sformatf("m%0d_err_hold", n), 32'(e), 32'(ler[n]));
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      chk("rst_rvalid0", 32'(m0_rvalid), 0);
      chk("rst_rvalid1", 32'(m1_rvalid), 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      chk("rst_err0", 32'(m0_err), 0);
      chk("rst_err1", 32'(m1_err), 0);
      lrd[0] = 0; lrd[1] = 0; ler[0] = 0; ler[1] = 0;
    end else begin
      mon(0, m0_rvalid, m0_rdata, m0_err);
      mon(1, m1_rvalid, m1_rdata, m1_err);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic r, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 16)
      0:       return ($urandom % DEPTH) * 4 + 1 + ($urandom % 3);
      1:       return (DEPTH + ($urandom % 64)) * 4;
      2:       return $urandom;
      default: return ($urandom % 8) * 4;
    endcase
  endfunction

  task automatic new_txn(input int n);
    logic r, we, lk;
    r  = ($urandom % 10) < 7;
    we = $urandom % 2;
    lk = ($urandom % 4) == 0;
    if (n == 0) set0(r, we, lk, rand_addr(), $urandom);
    else        set1(r, we, lk, rand_addr(), $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (3) step();
    mem_init = 1'b0;
    chk("reset_rdata0", m0_rdata, 0);

    // Tie after reset: m0 first, then m1
    rst_n = 1'b1;
    set0(1, 0, 0, 32'h0, 0);
    set1(1, 0, 0, 32'h4, 0);
    #3 chk("tie_gnt0_c1", 32'(m0_gnt), 1);
    chk("tie_gnt1_c1", 32'(m1_gnt), 0);
    step(); set0(0, 0, 0, 0, 0);
    #3 chk("tie_gnt1_c2", 32'(m1_gnt), 1);
    chk("tie_rvalid0_c2", 32'(m0_rvalid), 1);
    step(); set1(0, 0, 0, 0, 0);
    #3 chk("tie_rvalid1_c3", 32'(m1_rvalid), 1);

    // Store then load, no bubble
    step(); set0(1, 1, 0, 32'h10, 32'hDEADBEEF);
    #3 chk("st_wen", 32'(mem_w_en), 1);
    step(); set0(1, 0, 0, 32'h10, 0);
    #3 chk("st_rvalid", 32'(m0_rvalid), 1);
    step(); set0(0, 0, 0, 0, 0);
    #3 chk("ld_rvalid", 32'(m0_rvalid), 1);
    chk("ld_rdata", m0_rdata, 32'hDEADBEEF);
    chk("ld_err", 32'(m0_err), 0);

    // m1 locks for four accesses while m0 keeps requesting
    step(); set0(1, 0, 0, 32'h24, 0);
    for (int k = 0; k < 4; k++) begin
      set1(1, 0, (k < 3), 32'h20, 0);
      #3 chk("lock_gnt1", 32'(m1_gnt), 1);
      chk("lock_gnt0", 32'(m0_gnt), 0);
      step();
    end
    set1(0, 0, 0, 0, 0);
    #3 chk("unlock_gnt0", 32'(m0_gnt), 1);

    // Misaligned then out-of-range stores
    step(); set0(1, 1, 0, 32'h102, 32'h1111);
    #3 chk("mis_wen", 32'(mem_w_en), 0);
    step(); set0(1, 1, 0, 32'h100, 32'h2222);
    #3 chk("oor_wen", 32'(mem_w_en), 0);
    chk("mis_err", 32'(m0_err), 1);
    chk("mis_rdata", m0_rdata, 0);
    step(); set0(0, 0, 0, 0, 0);
    #3 chk("oor_err", 32'(m0_err), 1);
    chk("oor_rdata", m0_rdata, 0);

    // Reset while m1 owns the memory
    step(); set0(1, 0, 0, 32'h34, 0); set1(1, 1, 1, 32'h30, 32'h33);
    #3 chk("own1_gnt1", 32'(m1_gnt), 1);
    step();
    #2 rst_n = 1'b0;
    #1 chk("rst_drop_gnt1", 32'(m1_gnt), 0);
    chk("rst_drop_rvalid1", 32'(m1_rvalid), 0);
    chk("rst_drop_wen", 32'(mem_w_en), 0);
    step(); step();
    rst_n = 1'b1;
    set1(1, 0, 0, 32'h30, 0);
    #3 chk("post_rst_gnt0", 32'(m0_gnt), 1);
    chk("post_rst_gnt1", 32'(m1_gnt), 0);
    step(); set0(0, 0, 0, 0, 0);
    step(); set1(0, 0, 0, 0, 0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (mg0 || !m0_req) new_txn(0);
      if (mg1 || !m1_req) new_txn(1);
      step();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (3) step();
    chk("drain_queues", 32'(q0.size() + q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the shared data memory.
REQ-002 Parameter AW, default 32, requester byte-address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mN_req  input  1  requester N (N=0,1) access request; held until granted.
REQ-006 mN_we  input  1  requester N write enable; 1=store, 0=load.
REQ-007 mN_lock  input  1  requester N asks to keep ownership after its current grant.
REQ-008 mN_addr  input  AW  requester N byte address.
REQ-009 mN_wdata  input  32  requester N store data.
REQ-010 mN_gnt  output  1  requester N access accepted this cycle (combinational).
REQ-011 mN_rvalid  output  1  requester N completion pulse, one cycle after its grant.
REQ-012 mN_rdata  output  32  requester N load data, valid with mN_rvalid.
REQ-013 mN_err  output  1  requester N error flag, valid with mN_rvalid.
REQ-014 mem_w_en  output  1  write strobe to the data memory.
REQ-015 mem_w_addr  output  32  byte address to the data memory, shared by read and write.
REQ-016 mem_w_data  output  32  store data to the data memory.
REQ-017 mem_r_data  input  32  asynchronous read data from the data memory at mem_w_addr.

Function
REQ-018 At most one of m0_gnt/m1_gnt SHALL be high in any cycle, and each SHALL be high only when the matching mN_req is high.
REQ-019 State machine SHALL have states ARB (no owner), OWN0 and OWN1.
REQ-020 In ARB with a single requester, that requester SHALL be granted in the same cycle.
REQ-021 In ARB with both requesting, the requester not granted most recently SHALL win; the round-robin pointer SHALL reset so that m0 wins the first tie.
REQ-022 A grant with mN_lock=1 SHALL move ARB to OWNn; in OWNn only requester n SHALL be granted, whatever the other requester does.
REQ-023 OWNn SHALL return to ARB at the end of any cycle where mN_req=0 or mN_lock=0; the cycle in which the lock drops SHALL still grant requester n if mN_req=1.
REQ-024 The round-robin pointer SHALL update on every grant to the granted requester.
REQ-025 mem_w_addr and mem_w_data SHALL mux from the granted requester, or from m0 when nothing is granted.
REQ-026 A granted access SHALL be an error when addr[1:0]!=0 or (addr>>2)>=DEPTH.
REQ-027 mem_w_en SHALL be 1 only when a requester is granted with mN_we=1 and no error; it is combinational, so the write lands at the same posedge.
REQ-028 On every grant, mN_rvalid SHALL go high for exactly the next cycle, for stores as well as loads.
REQ-029 mN_rdata SHALL register mem_r_data as sampled in the grant cycle for a load without error; otherwise it SHALL register 0.
REQ-030 mN_err SHALL register the error condition from the grant cycle.
REQ-031 Outside the rvalid cycle, mN_rdata and mN_err SHALL hold their last value.
REQ-032 Back-to-back grants to one requester SHALL sustain one access per cycle with no bubble.
REQ-033 A load granted one cycle after a store to the same address SHALL return the stored data.

Reset
REQ-034 While rst_n=0, asynchronously: state=ARB, pointer=m1 (so m0 wins the first tie), all mN_rvalid/mN_err=0, all mN_rdata=0.
REQ-035 While rst_n=0, mN_gnt and mem_w_en SHALL be forced to 0.
REQ-036 Reset asserted mid-lock or in an rvalid cycle SHALL drop ownership and suppress the pending completion.
REQ-037 The first grant SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-038 Tie: m0 and m1 both request loads with equal timing -> m0 is granted in cycle 1 and m1 in cycle 2; rvalid arrives one cycle after each grant.
REQ-039 Store then load: m0 stores 0xDEADBEEF to 0x10, then loads 0x10 in the next cycle -> m0_rvalid on both, m0_rdata=0xDEADBEEF, m0_err=0.
REQ-040 Lock: m1 holds lock for 4 accesses while m0 requests continuously -> m1 gets 4 consecutive grants and m0_gnt stays 0; m0 is granted in the cycle after m1's lock drops.
REQ-041 Errors: m0 stores to 0x102 (misaligned), then to 0x100 with DEPTH=64 (out of range) -> mem_w_en=0 both cycles, m0_err=1, m0_rdata=0.
REQ-042 Reset mid-lock: assert rst_n=0 during OWN1 -> gnt, rvalid and mem_w_en drop immediately; after release, simultaneous requests grant m0 first.
